// File: rtl/tetris_pkg.sv
// Shared definitions for the falling-piece sequencer: key codes, field size,
// state encoding and packed-cell helpers.
package tetris_pkg;

  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_DOWN  = 8'h16;

  localparam int COLS   = 10;
  localparam int ROWS   = 20;
  localparam int CELL_W = 5;
  localparam int CELLS  = 4;
  localparam int PACK_W = CELL_W * CELLS;

  typedef enum logic [2:0] {SPAWN, IDLE, CHECK, LOCK, OVER} seq_state_t;
  typedef enum logic [1:0] {MV_LEFT, MV_RIGHT, MV_DOWN, MV_GRAV} move_t;

  function automatic logic is_move_key(input logic [7:0] k);
    return (k == KEY_LEFT) || (k == KEY_RIGHT) || (k == KEY_DOWN);
  endfunction

  function automatic move_t key_to_move(input logic [7:0] k);
    move_t m;
    m = MV_DOWN;
    if (k == KEY_LEFT)  m = MV_LEFT;
    if (k == KEY_RIGHT) m = MV_RIGHT;
    return m;
  endfunction

  // Adds d to every cell modulo 32; stepping left off column 0 wraps to 31,
  // which the bounds test below then rejects.
  function automatic logic [PACK_W-1:0] shift_cells(input logic [PACK_W-1:0] c,
                                                    input logic [CELL_W-1:0] d);
    logic [PACK_W-1:0] r;
    r = '0;
    for (int i = 0; i < CELLS; i++) r[i*CELL_W +: CELL_W] = c[i*CELL_W +: CELL_W] + d;
    return r;
  endfunction

  function automatic logic in_field(input logic [PACK_W-1:0] cx, input logic [PACK_W-1:0] cy);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < CELLS; i++) begin
      if (cx[i*CELL_W +: CELL_W] >= CELL_W'(COLS) || cy[i*CELL_W +: CELL_W] >= CELL_W'(ROWS))
        ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/fall_timer.sv
// Brings the asynchronous frame strobe into the Clk domain and divides its
// rising edges down to one gravity pulse every FALL_FRAMES frames.
module fall_timer #(
  parameter int FALL_FRAMES = 15
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic gravity
);

  // sync_q[1:0] is the two-flop synchronizer, sync_q[2] the edge-detect history.
  logic [2:0] sync_q, sync_d;
  logic [4:0] cnt_q, cnt_d;
  logic       tick;

  always_comb begin
    sync_d  = {sync_q[1:0], frame_clk};
    tick    = sync_q[1] & ~sync_q[2];
    cnt_d   = cnt_q;
    if (tick) cnt_d = (cnt_q == 5'(FALL_FRAMES)) ? 5'd1 : cnt_q + 5'd1;
    gravity = tick && (cnt_d == 5'(FALL_FRAMES));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/piece_sequencer.sv
// Moves one horizontal 4-cell piece through spawn, player moves, gravity and
// locking, handshaking collision checks and locks with an external board.
module piece_sequencer
  import tetris_pkg::*;
#(
  parameter int FALL_FRAMES = 15,
  parameter int SPAWN_COL   = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [7:0]        keycode,
  output logic              chk_req,
  output logic [PACK_W-1:0] cand_x,
  output logic [PACK_W-1:0] cand_y,
  input  logic              chk_ack,
  input  logic              chk_hit,
  output logic              lock_req,
  input  logic              lock_done,
  input  logic [2:0]        lines,
  output logic [PACK_W-1:0] x_block,
  output logic [PACK_W-1:0] y_block,
  output logic [15:0]       line_count,
  output logic              game_over
);

  localparam logic [PACK_W-1:0] SPAWN_X = {CELL_W'(SPAWN_COL + 3), CELL_W'(SPAWN_COL + 2),
                                           CELL_W'(SPAWN_COL + 1), CELL_W'(SPAWN_COL)};

  seq_state_t        state_q, state_d;
  logic              chk_req_q, chk_req_d;
  logic [PACK_W-1:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic [PACK_W-1:0] x_q, x_d, y_q, y_d;
  logic [15:0]       line_count_q, line_count_d;
  move_t             mv_q, mv_d, key_mv_q, key_mv_d, mv;
  logic              key_pend_q, key_pend_d, grav_pend_q, grav_pend_d;
  logic [7:0]        key_prev_q;
  logic [PACK_W-1:0] cx, cy;
  logic [16:0]       sum;
  logic              gravity, key_evt;

  fall_timer #(.FALL_FRAMES(FALL_FRAMES)) u_fall_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .frame_clk(frame_clk),
    .gravity  (gravity)
  );

  assign key_evt = is_move_key(keycode) && (keycode != key_prev_q);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    chk_req_d    = chk_req_q;
    cand_x_d     = cand_x_q;
    cand_y_d     = cand_y_q;
    mv_d         = mv_q;
    x_d          = x_q;
    y_d          = y_q;
    line_count_d = line_count_q;
    key_pend_d   = key_pend_q | key_evt;
    key_mv_d     = key_evt ? key_to_move(keycode) : key_mv_q;
    grav_pend_d  = grav_pend_q | gravity;
    mv           = MV_GRAV;
    cx           = x_q;
    cy           = y_q;
    sum          = {1'b0, line_count_q} + 17'(lines);

    unique case (state_q)
      SPAWN: begin
        if (!chk_req_q) begin
          chk_req_d = 1'b1;
          cand_x_d  = SPAWN_X;
          cand_y_d  = '0;
        end else if (chk_ack) begin
          chk_req_d = 1'b0;
          if (chk_hit) begin
            state_d = OVER;
          end else begin
            x_d     = cand_x_q;
            y_d     = cand_y_q;
            state_d = IDLE;
          end
        end
      end
      IDLE: begin
        if (key_pend_q || grav_pend_q) begin
          // Player input wins over gravity; the gravity flag stays pending.
          if (key_pend_q) begin
            mv         = key_mv_q;
            key_pend_d = key_evt;
          end else begin
            grav_pend_d = gravity;
          end
          unique case (mv)
            MV_LEFT:  cx = shift_cells(x_q, '1);
            MV_RIGHT: cx = shift_cells(x_q, CELL_W'(1));
            default:  cy = shift_cells(y_q, CELL_W'(1));
          endcase
          if (in_field(cx, cy)) begin
            state_d   = CHECK;
            chk_req_d = 1'b1;
            cand_x_d  = cx;
            cand_y_d  = cy;
            mv_d      = mv;
          end else if (mv == MV_DOWN || mv == MV_GRAV) begin
            state_d = LOCK;
          end
        end
      end
      CHECK: begin
        if (chk_ack) begin
          chk_req_d = 1'b0;
          if (!chk_hit) begin
            x_d     = cand_x_q;
            y_d     = cand_y_q;
            state_d = IDLE;
          end else begin
            state_d = (mv_q == MV_LEFT || mv_q == MV_RIGHT) ? IDLE : LOCK;
          end
        end
      end
      LOCK: begin
        if (lock_done) begin
          line_count_d = sum[16] ? 16'hFFFF : sum[15:0];
          key_pend_d   = 1'b0;
          grav_pend_d  = 1'b0;
          state_d      = SPAWN;
        end
      end
      OVER: begin
        key_pend_d  = 1'b0;
        grav_pend_d = 1'b0;
      end
      default: state_d = SPAWN;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= SPAWN;
      chk_req_q    <= 1'b0;
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      mv_q         <= MV_GRAV;
      x_q          <= SPAWN_X;
      y_q          <= '0;
      line_count_q <= '0;
      key_pend_q   <= 1'b0;
      key_mv_q     <= MV_LEFT;
      grav_pend_q  <= 1'b0;
      key_prev_q   <= '0;
    end else begin
      state_q      <= state_d;
      chk_req_q    <= chk_req_d;
      cand_x_q     <= cand_x_d;
      cand_y_q     <= cand_y_d;
      mv_q         <= mv_d;
      x_q          <= x_d;
      y_q          <= y_d;
      line_count_q <= line_count_d;
      key_pend_q   <= key_pend_d;
      key_mv_q     <= key_mv_d;
      grav_pend_q  <= grav_pend_d;
      key_prev_q   <= keycode;
    end
  end

  assign chk_req    = chk_req_q;
  assign cand_x     = cand_x_q;
  assign cand_y     = cand_y_q;
  assign lock_req   = (state_q == LOCK);
  assign x_block    = x_q;
  assign y_block    = y_q;
  assign line_count = line_count_q;
  assign game_over  = (state_q == OVER);

endmodule

// File: tb/tb_piece_sequencer.sv
// Self-checking bench for piece_sequencer: acts as the board, predicts every
// collision-check candidate in a scoreboard and tracks the piece position.
module tb_piece_sequencer;

  localparam logic [7:0] KA = 8'h04;
  localparam logic [7:0] KD = 8'h07;
  localparam logic [7:0] KS = 8'h16;

  logic        Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0;
  logic [7:0]  keycode = '0;
  logic        chk_req, chk_ack = 1'b0, chk_hit = 1'b0;
  logic [19:0] cand_x, cand_y, x_block, y_block;
  logic        lock_req, lock_done = 1'b0, game_over;
  logic [2:0]  lines = '0;
  logic [15:0] line_count;

  piece_sequencer #(.FALL_FRAMES(15), .SPAWN_COL(3)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .chk_req(chk_req), .cand_x(cand_x), .cand_y(cand_y),
    .chk_ack(chk_ack), .chk_hit(chk_hit), .lock_req(lock_req),
    .lock_done(lock_done), .lines(lines), .x_block(x_block), .y_block(y_block),
    .line_count(line_count), .game_over(game_over)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [19:0] cx; logic [19:0] cy; } cand_t;
  typedef struct { logic [7:0] key; logic hit; logic exp_req; int exp_col; int exp_row; } vec_t;

  cand_t sb[$];
  vec_t  vecs[9];
  int    checks = 0, errors = 0;
  int    req_rises = 0, base = 0, col = 0, row = 0, cc = 0, cr = 0;
  logic  req_prev = 1'b0;
  bit    seen;

  always @(negedge Clk) begin
    if (chk_req && !req_prev) req_rises++;
    req_prev = chk_req;
  end

  function automatic logic [19:0] px(input int c);
    return {5'(c + 3), 5'(c + 2), 5'(c + 1), 5'(c)};
  endfunction

  function automatic logic [19:0] py(input int r);
    return {4{5'(r)}};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (chk_req) begin ok = 1'b1; break; end
      @(negedge Clk);
    end
  endtask

  task automatic wait_lock(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (lock_req) begin ok = 1'b1; break; end
      @(negedge Clk);
    end
  endtask

  // Board side of one check: compare the candidate with the oldest prediction, then ack.
  task automatic serve(input string name, input logic hit);
    bit    ok;
    cand_t e;
    wait_req(60, ok);
    check({name, " chk_req seen"}, 32'(ok), 32'd1);
    if (sb.size() == 0) begin
      check({name, " scoreboard entry"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({name, " cand_x"}, 32'(cand_x), 32'(e.cx));
      check({name, " cand_y"}, 32'(cand_y), 32'(e.cy));
    end
    chk_ack = 1'b1;
    chk_hit = hit;
    @(negedge Clk);
    chk_ack = 1'b0;
    chk_hit = 1'b0;
    check({name, " chk_req drop"}, 32'(chk_req), 32'd0);
  endtask

  task automatic press(input logic [7:0] k);
    keycode = k;
    @(negedge Clk);
    keycode = '0;
    @(negedge Clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1;
      repeat (4) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (4) @(negedge Clk);
    end
  endtask

  task automatic check_piece(input string name, input int c, input int r);
    check({name, " x_block"}, 32'(x_block), 32'(px(c)));
    check({name, " y_block"}, 32'(y_block), 32'(py(r)));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{KD, 1'b0, 1'b1, 4, 1};
    vecs[1] = '{KD, 1'b0, 1'b1, 5, 1};
    vecs[2] = '{KD, 1'b1, 1'b1, 5, 1};
    vecs[3] = '{KD, 1'b0, 1'b1, 6, 1};
    vecs[4] = '{KD, 1'b0, 1'b0, 6, 1};
    vecs[5] = '{KA, 1'b0, 1'b1, 5, 1};
    vecs[6] = '{KS, 1'b0, 1'b1, 5, 2};
    vecs[7] = '{KA, 1'b1, 1'b1, 5, 2};
    vecs[8] = '{KA, 1'b0, 1'b1, 4, 2};

    // Reset state
    @(negedge Clk);
    check("rst chk_req", 32'(chk_req), 32'd0);
    check("rst lock_req", 32'(lock_req), 32'd0);
    check("rst game_over", 32'(game_over), 32'd0);
    check("rst line_count", 32'(line_count), 32'd0);
    check("rst cand_x", 32'(cand_x), 32'd0);
    check("rst cand_y", 32'(cand_y), 32'd0);
    check_piece("rst", 3, 0);
    @(negedge Clk);
    Reset = 1'b0;

    // Spawn check with a miss
    sb.push_back('{px(3), py(0)});
    serve("spawn", 1'b0);
    col = 3; row = 0;
    check_piece("spawn", col, row);

    // Gravity after exactly 15 frame edges
    base = req_rises;
    frames(14);
    check("14 frames no req", 32'(req_rises - base), 32'd0);
    sb.push_back('{px(3), py(1)});
    frames(1);
    serve("gravity", 1'b0);
    row = 1;
    repeat (20) @(negedge Clk);
    check("one gravity req", 32'(req_rises - base), 32'd1);
    check_piece("gravity", col, row);

    // Table of single moves
    for (int i = 0; i < 9; i++) begin
      cc = col; cr = row; base = req_rises;
      if (vecs[i].key == KA) cc = cc - 1;
      else if (vecs[i].key == KD) cc = cc + 1;
      else cr = cr + 1;
      if (vecs[i].exp_req) begin
        sb.push_back('{px(cc), py(cr)});
        press(vecs[i].key);
        serve($sformatf("vec%0d", i), vecs[i].hit);
      end else begin
        press(vecs[i].key);
        repeat (6) @(negedge Clk);
        check($sformatf("vec%0d no req", i), 32'(req_rises - base), 32'd0);
      end
      col = vecs[i].exp_col; row = vecs[i].exp_row;
      check_piece($sformatf("vec%0d", i), col, row);
    end

    // Stray completions in IDLE are ignored
    base = req_rises;
    chk_ack = 1'b1; chk_hit = 1'b1; lock_done = 1'b1; lines = 3'd4;
    @(negedge Clk);
    chk_ack = 1'b0; chk_hit = 1'b0; lock_done = 1'b0; lines = '0;
    repeat (3) @(negedge Clk);
    check("stray line_count", 32'(line_count), 32'd0);
    check("stray no req", 32'(req_rises - base), 32'd0);
    check_piece("stray", col, row);

    // Key and gravity both pending while a check is held: move first, then fall
    base = req_rises;
    sb.push_back('{px(col), py(row + 1)});
    press(KS);
    wait_req(20, seen);
    check("hold req seen", 32'(seen), 32'd1);
    press(KA);
    frames(15);
    serve("hold S", 1'b0);
    row = row + 1;
    sb.push_back('{px(col - 1), py(row)});
    sb.push_back('{px(col - 1), py(row + 1)});
    serve("pend A", 1'b0);
    col = col - 1;
    check_piece("pend A", col, row);
    serve("pend grav", 1'b0);
    row = row + 1;
    check_piece("pend grav", col, row);
    check("pend req count", 32'(req_rises - base), 32'd3);

    // Walk to the left wall, then a rejected left move
    while (col > 0) begin
      sb.push_back('{px(col - 1), py(row)});
      press(KA);
      serve("walk A", 1'b0);
      col = col - 1;
    end
    base = req_rises;
    press(KA);
    repeat (6) @(negedge Clk);
    check("left wall no req", 32'(req_rises - base), 32'd0);
    check_piece("left wall", col, row);

    // Drop to the floor, then a gravity step locks without a check
    while (row < 19) begin
      sb.push_back('{px(col), py(row + 1)});
      press(KS);
      serve("drop S", 1'b0);
      row = row + 1;
    end
    base = req_rises;
    frames(15);
    wait_lock(40, seen);
    check("floor lock_req", 32'(seen), 32'd1);
    check("floor no req", 32'(req_rises - base), 32'd0);
    check_piece("floor", col, row);
    lock_done = 1'b1; lines = 3'd3;
    @(negedge Clk);
    lock_done = 1'b0; lines = '0;
    check("lines 3", 32'(line_count), 32'd3);
    check("lock_req drop", 32'(lock_req), 32'd0);
    sb.push_back('{px(3), py(0)});
    serve("respawn", 1'b0);
    col = 3; row = 0;
    check_piece("respawn", col, row);

    // Saturation of the cleared-row counter
    force dut.line_count_q = 16'hFFFE;
    @(negedge Clk);
    release dut.line_count_q;
    @(negedge Clk);
    check("preload", 32'(line_count), 32'hFFFE);
    sb.push_back('{px(3), py(1)});
    press(KS);
    serve("S hit", 1'b1);
    wait_lock(10, seen);
    check("S hit lock_req", 32'(seen), 32'd1);
    repeat (3) @(negedge Clk);
    check("lock_req held", 32'(lock_req), 32'd1);
    check_piece("lock held", col, row);
    lock_done = 1'b1; lines = 3'd4;
    @(negedge Clk);
    lock_done = 1'b0; lines = '0;
    check("saturate", 32'(line_count), 32'hFFFF);

    // Spawn collision ends the game; everything afterwards is ignored
    sb.push_back('{px(3), py(0)});
    serve("spawn hit", 1'b1);
    check("game_over", 32'(game_over), 32'd1);
    base = req_rises;
    press(KA); press(KD); press(KS);
    frames(15);
    chk_ack = 1'b1; lock_done = 1'b1; lines = 3'd2;
    @(negedge Clk);
    chk_ack = 1'b0; lock_done = 1'b0; lines = '0;
    repeat (4) @(negedge Clk);
    check("over no req", 32'(req_rises - base), 32'd0);
    check("over held", 32'(game_over), 32'd1);
    check("over lock_req", 32'(lock_req), 32'd0);
    check("over line_count", 32'(line_count), 32'hFFFF);

    // Reset clears the sticky state
    Reset = 1'b1;
    #1;
    check("reset game_over", 32'(game_over), 32'd0);
    check("reset line_count", 32'(line_count), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    sb.push_back('{px(3), py(0)});
    serve("spawn2", 1'b0);

    // Reset in the middle of a check drops the request and ignores a late ack
    press(KS);
    wait_req(20, seen);
    check("midchk req", 32'(seen), 32'd1);
    Reset = 1'b1; chk_ack = 1'b1;
    #1;
    check("midchk drop", 32'(chk_req), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk_ack = 1'b0;
    check_piece("midchk", 3, 0);
    sb.push_back('{px(3), py(0)});
    serve("spawn3", 1'b0);

    // Reset in the middle of a lock drops the request and ignores lock_done
    sb.push_back('{px(3), py(1)});
    press(KS);
    serve("S hit2", 1'b1);
    wait_lock(10, seen);
    check("midlock lock_req", 32'(seen), 32'd1);
    Reset = 1'b1; lock_done = 1'b1; lines = 3'd4;
    #1;
    check("midlock drop", 32'(lock_req), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    lock_done = 1'b0; lines = '0;
    check("midlock line_count", 32'(line_count), 32'd0);
    sb.push_back('{px(3), py(0)});
    serve("spawn4", 1'b0);
    check("sb empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
